// File: rtl/mem_pkg.sv
// Shared memory-system constants and the bank-select helper used by the banked
// memory model and by the cache FSM's offset sequencing.
package mem_pkg;

    localparam int MEM_ADDR_W   = 16;
    localparam int MEM_DATA_W   = 16;
    localparam int NBANK_LOG2   = 2;
    localparam int MEM_RD_LAT   = 2;
    localparam int MEM_BUSY_CYC = 4;

    typedef logic [MEM_ADDR_W-1:0]  mem_addr_t;
    typedef logic [MEM_DATA_W-1:0]  mem_word_t;
    typedef logic [NBANK_LOG2-1:0]  mem_bank_t;

    // Word-interleaved banking: consecutive 16-bit words land in consecutive banks.
    function automatic mem_bank_t bank_of(input mem_addr_t a);
        return a[NBANK_LOG2:1];
    endfunction

endpackage

// File: rtl/banked_mem_ctrl_bank_busy_ctr.sv
// Per-bank occupancy down-counter: loads on an accepted access and reports the
// bank busy until the count drains back to zero.
module bank_busy_ctr
    import mem_pkg::*;
#(
    parameter int BUSY_CYC = MEM_BUSY_CYC
) (
    input  logic clk,
    input  logic srst,
    input  logic load,
    output logic busy
);

    localparam int CNT_W = (BUSY_CYC > 1) ? $clog2(BUSY_CYC) : 1;

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else if (load) begin
            // The accept cycle itself counts as the first busy cycle.
            cnt_reg <= CNT_W'(BUSY_CYC - 1);
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign busy = (cnt_reg != '0);

endmodule

// File: rtl/banked_mem_ctrl.sv
// Four-way word-interleaved main-memory model with fixed read latency and
// per-bank busy time. Optional macro: BANKED_MEM_UNALIGNED_ERR_EN.
module banked_mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int NBANK_LOG2 = mem_pkg::NBANK_LOG2,
    parameter int RD_LAT     = MEM_RD_LAT,
    parameter int BUSY_CYC   = MEM_BUSY_CYC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     stall,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_valid,
    output logic [2**NBANK_LOG2-1:0] busy,
    output logic                     err
);

    localparam int NBANK  = 2**NBANK_LOG2;
    localparam int WORD_W = ADDR_W - 1;
    localparam int WORDS  = 2**WORD_W;

    logic [WORD_W-1:0]     word_addr;
    logic [NBANK_LOG2-1:0] bank_sel;
    logic                  req;
    logic                  both;
    logic                  unaligned;
    logic                  bank_busy;
    logic                  accept;
    logic                  accept_wr;
    logic                  accept_rd;
    logic [NBANK-1:0]      bank_load;

    assign word_addr = addr[ADDR_W-1:1];
    assign bank_sel  = addr[NBANK_LOG2:1];
    assign req       = wr ^ rd;
    assign both      = wr & rd;

`ifdef BANKED_MEM_UNALIGNED_ERR_EN
    assign unaligned = req & addr[0];
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = addr[0];
    assign unaligned       = 1'b0;
`endif

    assign bank_busy = busy[bank_sel];

    // Requests seen while rst is high are neither accepted nor flagged.
    assign err       = ~rst & (both | unaligned);
    assign stall     = ~rst & req & ~unaligned & bank_busy;
    assign accept    = ~rst & req & ~unaligned & ~bank_busy;
    assign accept_wr = accept & wr;
    assign accept_rd = accept & rd;

    genvar gi;

    generate
        for (gi = 0; gi < NBANK; gi++) begin : g_bank
            assign bank_load[gi] = accept & (bank_sel == NBANK_LOG2'(gi));

            bank_busy_ctr #(
                .BUSY_CYC (BUSY_CYC)
            ) u_busy_ctr (
                .clk  (clk),
                .srst (rst),
                .load (bank_load[gi]),
                .busy (busy[gi])
            );
        end
    endgenerate

    // Read pipeline: stage gi is visible in cycle N+1+gi after the accept.
    logic [RD_LAT-1:0] rd_valid_reg;
    logic [WORD_W-1:0] rd_src_word;
    logic              rd_src_valid;

    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_rd_valid
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst) rd_valid_reg[gi] <= 1'b0;
                    else     rd_valid_reg[gi] <= accept_rd;
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (rst) rd_valid_reg[gi] <= 1'b0;
                    else     rd_valid_reg[gi] <= rd_valid_reg[gi-1];
                end
            end
        end

        if (RD_LAT > 1) begin : g_rd_addr
            logic [WORD_W-1:0] word_pipe_reg [RD_LAT-1];

            for (gi = 0; gi < RD_LAT - 1; gi++) begin : g_stage
                if (gi == 0) begin : g_head
                    always_ff @(posedge clk) word_pipe_reg[gi] <= word_addr;
                end else begin : g_tail
                    always_ff @(posedge clk) word_pipe_reg[gi] <= word_pipe_reg[gi-1];
                end
            end

            assign rd_src_word  = word_pipe_reg[RD_LAT-2];
            assign rd_src_valid = rd_valid_reg[RD_LAT-2];
        end else begin : g_rd_direct
            assign rd_src_word  = word_addr;
            assign rd_src_valid = accept_rd;
        end
    endgenerate

    // Behavioural storage; deliberately untouched by reset.
    logic [DATA_W-1:0] mem_array [WORDS];
    logic [DATA_W-1:0] data_out_reg;

    always_ff @(posedge clk) begin
        if (accept_wr) mem_array[word_addr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_reg <= '0;
        end else if (rd_src_valid) begin
            data_out_reg <= mem_array[rd_src_word];
        end
    end

    assign data_out   = data_out_reg;
    assign data_valid = rd_valid_reg[RD_LAT-1];

endmodule
